imem_program_loader: RTL and testbench

- Writer-side counterpart to the CPU's instruction-memory read path.
- Receives a framed program image over an 8-bit valid/ready byte stream and assembles it into 16-bit instruction words.
- Writes those words sequentially into the instruction memory write port, starting at address 0.
- Holds the CPU pipeline in reset via cpu_hold until a complete, checksum-verified image has been written.

---
 rtl/imem_program_loader.sv | 141 ++++++++++++++
 tb/tb_imem_program_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - framed byte-stream loader into instruction memory
// Holds the CPU in reset until a checksum-verified program image is written.
module imem_program_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK, ST_DONE, ST_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
  localparam logic [15:0] WC_SAT    = 16'(DEPTH);

  state_t      state, next_state;
  logic [7:0]  cnt_hi;
  logic [7:0]  hi_byte;
  logic [7:0]  csum;
  logic [15:0] len_q;
  logic [15:0] words_rx;
  logic [15:0] frame_len;
  logic        accept;
  logic        start_load;
  logic        ready_d, busy_d, done_d, error_d, hold_d;

  assign accept     = rx_valid && rx_ready;
  assign frame_len  = {cnt_hi, rx_data};
  assign start_load = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_CNT_HI;
      ST_CNT_HI:  if (accept) next_state = ST_CNT_LO;
      ST_CNT_LO: begin
        if (accept) begin
          if ({1'b0, frame_len} > DEPTH_L) next_state = ST_ERR;
          else if (frame_len == 16'd0)     next_state = ST_CHECK;
          else                             next_state = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) next_state = ST_DATA_LO;
      ST_DATA_LO: begin
        if (accept) next_state = (words_rx + 16'd1 == len_q) ? ST_CHECK : ST_DATA_HI;
      end
      ST_CHECK:   if (accept) next_state = (rx_data == csum) ? ST_DONE : ST_ERR;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from next_state and registered, so they track the state exactly.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    case (next_state)
      ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CHECK: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    done_d  = (next_state == ST_DONE);
    error_d = (next_state == ST_ERR);
    hold_d  = !done_d;
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
      word_count <= 16'd0;
      cnt_hi     <= 8'd0;
      hi_byte    <= 8'd0;
      csum       <= 8'd0;
      len_q      <= 16'd0;
      words_rx   <= 16'd0;
    end else begin
      rx_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
      cpu_hold <= hold_d;
      imem_we  <= 1'b0;
      // Address and count advance on the edge that ends the write pulse.
      if (imem_we) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        if (word_count != WC_SAT) word_count <= word_count + 16'd1;
      end
      if (accept && state != ST_CHECK) csum <= csum ^ rx_data;
      if (accept) begin
        case (state)
          ST_CNT_HI:  cnt_hi <= rx_data;
          ST_CNT_LO:  len_q  <= frame_len;
          ST_DATA_HI: hi_byte <= rx_data;
          ST_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_wdata <= {hi_byte, rx_data};
            words_rx   <= words_rx + 16'd1;
          end
          default: ;
        endcase
      end
      if (start_load) begin
        imem_addr  <= '0;
        word_count <= 16'd0;
        csum       <= 8'd0;
        words_rx   <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - table-driven bench for imem_program_loader
// Frames are replayed from a vector table; write pulses are logged on the falling edge.
module tb_imem_program_loader;

  logic        clk = 1'b0;
  logic        pc_reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_program_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .pc_reset(pc_reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [79:0] bytes;
    logic        stall;
    int          nw;
    logic [47:0] words;
    logic        exp_done;
    logic        exp_err;
    logic [15:0] exp_wc;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  wr_addr[64];
  logic [15:0] wr_data[64];
  int          wr_n = 0;
  int          long_cnt = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_n < 64) begin
        wr_addr[wr_n] = imem_addr;
        wr_data[wr_n] = imem_wdata;
      end
      wr_n++;
    end
    if (imem_we && prev_we) long_cnt++;
    prev_we = imem_we;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stall);
    int guard = 0;
    bit sent  = 0;
    while (!sent && guard < 200) begin
      @(negedge clk);
      guard++;
      if (stall && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
        sent     = rx_ready;
      end
    end
    if (!sent) chk("send_timeout", 32'(guard), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int base;
    int lbase;
    base  = wr_n;
    lbase = long_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_busy_start", id), 32'(busy), 32'd1);
    chk($sformatf("v%0d_done_clr", id), 32'(done), 32'd0);
    chk($sformatf("v%0d_err_clr", id), 32'(error), 32'd0);
    chk($sformatf("v%0d_hold_load", id), 32'(cpu_hold), 32'd1);
    for (int k = 0; k < v.n; k++) send_byte(v.bytes[79-8*k -: 8], v.stall);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_nwrites", id), 32'(wr_n - base), 32'(v.nw));
    for (int k = 0; k < v.nw; k++) begin
      chk($sformatf("v%0d_addr%0d", id, k), 32'(wr_addr[base+k]), 32'(k));
      chk($sformatf("v%0d_data%0d", id, k), 32'(wr_data[base+k]), 32'(v.words[47-16*k -: 16]));
    end
    chk($sformatf("v%0d_pulse_width", id), 32'(long_cnt - lbase), 32'd0);
    chk($sformatf("v%0d_done", id), 32'(done), 32'(v.exp_done));
    chk($sformatf("v%0d_error", id), 32'(error), 32'(v.exp_err));
    chk($sformatf("v%0d_hold", id), 32'(cpu_hold), 32'(!v.exp_done));
    chk($sformatf("v%0d_wc", id), 32'(word_count), 32'(v.exp_wc));
    chk($sformatf("v%0d_busy_end", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_ready_end", id), 32'(rx_ready), 32'd0);
  endtask

  initial begin
    int base;
    // 00^02^12^34^AB^CD = 42; 00^03^00^01^FF^FF^80^00 = 82
    vecs[0] = '{7, 80'h00021234ABCD42000000, 1'b0, 2, 48'h1234ABCD0000, 1'b1, 1'b0, 16'd2};
    vecs[1] = '{7, 80'h00021234ABCD6B000000, 1'b0, 2, 48'h1234ABCD0000, 1'b0, 1'b1, 16'd2};
    vecs[2] = '{2, 80'h01010000000000000000, 1'b0, 0, 48'h0,           1'b0, 1'b1, 16'd0};
    vecs[3] = '{3, 80'h00000000000000000000, 1'b0, 0, 48'h0,           1'b1, 1'b0, 16'd0};
    vecs[4] = '{9, 80'h00030001FFFF80008200, 1'b0, 3, 48'h0001FFFF8000, 1'b1, 1'b0, 16'd3};
    vecs[5] = '{7, 80'h00021234ABCD42000000, 1'b1, 2, 48'h1234ABCD0000, 1'b1, 1'b0, 16'd2};

    pc_reset = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    pc_reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset between the hi and lo bytes of word 1.
    base = wr_n;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    pc_reset = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(rx_ready), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_writes", 32'(wr_n - base), 32'd1);
    pc_reset = 1'b0;
    run_vec(vecs[0], 10);

    // cpu_hold must reassert without waiting for a clock edge.
    @(negedge clk);
    #2;
    pc_reset = 1'b1;
    #1;
    chk("async_hold", 32'(cpu_hold), 32'd1);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    pc_reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
